// File: rtl/regfile_pkg.sv
// regfile_pkg -- constants and types shared by the writeback arbiter slice.
//   DW       : default data width of every write-data path
//   NREG     : default number of architectural registers
//   AW       : register address width, log2(NREG)
//   req_id_e : identifies a writeback requester (ALU or load unit)
package regfile_pkg;

  localparam int DW   = 16;
  localparam int NREG = 16;
  localparam int AW   = 4;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LD  = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2 -- two-way round-robin grant for the writeback port.
// Ports:
//   clk, reset        : clock and asynchronous active-low reset
//   req_alu, req_ld   : request (valid) from each requester
//   gnt_alu, gnt_ld   : combinational grant (ready), low while reset is held
//   winner            : requester id of the current grant (ALU when idle)
// A lone requester is granted at once. When both request, the pointer
// picks the winner and flips afterwards, so uncontested grants never
// disturb the fairness order. The pointer resets to ALU-first.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    req_alu,
  input  logic    req_ld,
  output logic    gnt_alu,
  output logic    gnt_ld,
  output req_id_e winner
);

  req_id_e ptr_reg;
  req_id_e ptr_next;
  logic    contested;

  always_comb begin
    contested = req_alu & req_ld;
    gnt_alu   = 1'b0;
    gnt_ld    = 1'b0;
    ptr_next  = ptr_reg;
    // Grants are gated by reset so neither side sees ready while held.
    if (reset) begin
      if (contested) begin
        if (ptr_reg == REQ_ALU) begin
          gnt_alu  = 1'b1;
          ptr_next = REQ_LD;
        end else begin
          gnt_ld   = 1'b1;
          ptr_next = REQ_ALU;
        end
      end else begin
        gnt_alu = req_alu;
        gnt_ld  = req_ld;
      end
    end
    winner = gnt_ld ? REQ_LD : REQ_ALU;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg <= REQ_ALU;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter -- merges ALU and load-unit writebacks onto a single
// registered register-file write port and tracks pending writes.
// Ports:
//   clk, reset                   : clock, asynchronous active-low reset
//   alu_valid/ready/addr/data    : ALU writeback request handshake
//   ld_valid/ready/addr/data     : load-unit writeback request handshake
//   iss_valid, iss_addr          : issue stage marks iss_addr pending-write
//   rd_a0, rd_a1                 : sources of the instruction being issued
//   hazard                       : a source register has a pending write
//   busy                         : pending-write scoreboard, bit i = reg i
//   w_en, w_addr, w_data         : registered write port, one cycle after
//                                  the transfer
// Optional build macro REGFILE_ARB_ZERO_REG_EN: register 0 is hardwired
// zero. Writes to it are still accepted but never reach the write port, it
// is never marked busy and reading it never raises a hazard.
module regfile_wb_arbiter #(
  parameter  int DW   = regfile_pkg::DW,
  parameter  int NREG = regfile_pkg::NREG,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_addr,
  input  logic [DW-1:0]   alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_addr,
  input  logic [DW-1:0]   ld_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  input  logic [AW-1:0]   rd_a0,
  input  logic [AW-1:0]   rd_a1,
  output logic            hazard,
  output logic [NREG-1:0] busy,
  output logic            w_en,
  output logic [AW-1:0]   w_addr,
  output logic [DW-1:0]   w_data
);

  import regfile_pkg::*;

  logic            gnt_alu;
  logic            gnt_ld;
  req_id_e         winner;
  logic            xfer;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            w_en_next;
  logic            w_en_reg;
  logic [AW-1:0]   w_addr_reg;
  logic [DW-1:0]   w_data_reg;
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_alu (alu_valid),
    .req_ld  (ld_valid),
    .gnt_alu (gnt_alu),
    .gnt_ld  (gnt_ld),
    .winner  (winner)
  );

  assign alu_ready = gnt_alu;
  assign ld_ready  = gnt_ld;

  always_comb begin
    xfer     = (alu_valid & gnt_alu) | (ld_valid & gnt_ld);
    win_addr = (winner == REQ_LD) ? ld_addr : alu_addr;
    win_data = (winner == REQ_LD) ? ld_data : alu_data;
`ifdef REGFILE_ARB_ZERO_REG_EN
    w_en_next = xfer && (win_addr != '0);
`else
    w_en_next = xfer;
`endif
  end

  // Address/data only load on a transfer; w_en qualifies them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_en_reg   <= 1'b0;
      w_addr_reg <= '0;
      w_data_reg <= '0;
    end else begin
      w_en_reg <= w_en_next;
      if (xfer) begin
        w_addr_reg <= win_addr;
        w_data_reg <= win_data;
      end
    end
  end

  // Scoreboard: a new issue to a register wins over a write retiring the
  // older pending value of that same register in the same cycle.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
    logic set_hit;
    logic clr_hit;
    assign set_hit = iss_valid && (iss_addr == AW'(gi));
    assign clr_hit = w_en_reg && (w_addr_reg == AW'(gi));
`ifdef REGFILE_ARB_ZERO_REG_EN
    if (gi == 0) begin : g_zero
      assign busy_next[gi] = 1'b0;
    end else begin : g_norm
      assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
    end
`else
    assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

`ifdef REGFILE_ARB_ZERO_REG_EN
  assign hazard = ((rd_a0 != '0) & busy_reg[rd_a0]) |
                  ((rd_a1 != '0) & busy_reg[rd_a1]);
`else
  assign hazard = busy_reg[rd_a0] | busy_reg[rd_a1];
`endif

  assign busy   = busy_reg;
  assign w_en   = w_en_reg;
  assign w_addr = w_addr_reg;
  assign w_data = w_data_reg;

endmodule
